// File: rtl/if_id_queue.sv
// Four-entry instruction queue between fetch and decode: filters fetch bubbles,
// flushes on redirect, and presents a NOP whenever it is empty.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [2:0]  count,
  output logic [7:0]  drop_cnt
);

  localparam logic [2:0] FULL_CNT = 3'(DEPTH);

  logic [31:0] r_pc_mem   [0:3];
  logic [31:0] r_inst_mem [0:3];
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_wr_ptr;
  logic [2:0]  r_count;
  logic [7:0]  r_drop_cnt;

  logic w_bubble;
  logic w_push;
  logic w_pop;
  logic w_not_empty;

  // An all-zero pc/inst pair is a fetch bubble; inst==0 alone is a real NOP.
  assign w_bubble    = (in_inst == 32'd0) && (in_pc == 32'd0);
  assign w_not_empty = (r_count != 3'd0);
  assign in_ready    = (r_count < FULL_CNT);
  assign w_push      = in_valid && in_ready && !flush && !w_bubble;
  assign w_pop       = w_not_empty && out_ready && !flush;

  // Storage carries no reset; validity lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (flush) begin
        r_rd_ptr <= 2'd0;
        r_wr_ptr <= 2'd0;
        r_count  <= 3'd0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 3'd1;
          2'b01:   r_count <= r_count - 3'd1;
          default: r_count <= r_count;
        endcase
      end
      if (in_valid && w_bubble && !flush && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign out_valid = w_not_empty;
  assign out_pc    = w_not_empty ? r_pc_mem[r_rd_ptr]   : 32'd0;
  assign out_inst  = w_not_empty ? r_inst_mem[r_rd_ptr] : 32'd0;
  assign count     = r_count;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  if_id_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] mq[$];
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle: check combinational outputs against the model, advance the
  // model by the queue rules, clock, then check the registered state.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic fl, input logic ordy);
    logic bub, do_push, do_pop;
    in_valid = v; in_pc = pc; in_inst = inst; flush = fl; out_ready = ordy;
    #1;
    chk("in_ready",  32'(in_ready),  32'(mq.size() < 4));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_pc",    out_pc,   (mq.size() != 0) ? mq[0][63:32] : 32'd0);
    chk("out_inst",  out_inst, (mq.size() != 0) ? mq[0][31:0]  : 32'd0);
    bub = (pc == 0) && (inst == 0);
    if (fl) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && ordy;
      do_push = v && (mq.size() < 4) && !bub;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc, inst});
    end
    if (v && bub && !fl && m_drop < 255) m_drop++;
    @(posedge clk);
    #1;
    chk("count",    32'(count),    32'(mq.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_pc = 0; in_inst = 0; flush = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    out_pc,         32'd0);
    chk("rst_inst",  out_inst,       32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_drop",  32'(drop_cnt),  32'd0);
    reset = 1'b0;

    // Fill then drain
    for (int i = 0; i < 4; i++)
      step(1'b1, (i == 0) ? 32'hbfc00000 : 32'(i * 4), 32'h24010001 + 32'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'h10, 32'h24010005, 1'b0, 1'b0);
    chk("fifth_rej", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("drain_cnt",  32'(count), 32'd0);
    chk("drain_inst", out_inst,   32'd0);

    // Wrap-around with occupancy held at two
    step(1'b1, 32'h1000, 32'hA0, 1'b0, 1'b0);
    step(1'b1, 32'h1004, 32'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_head", out_pc, 32'h1000 + 32'(4 * i));
      step(1'b1, 32'h1008 + 32'(4 * i), 32'hA2 + 32'(i), 1'b0, 1'b1);
      chk("wrap_cnt", 32'(count), 32'd2);
    end
    step(1'b1, 32'd0, 32'd0, 1'b1, 1'b0);

    // Flush collides with push and pop
    for (int i = 0; i < 3; i++) step(1'b1, 32'h2000 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h200c, 32'hB3, 1'b1, 1'b1);
    chk("flush_cnt",   32'(count),     32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    idle();

    // Bubble filter
    for (int i = 0; i < 3; i++) step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h100, 32'd0, 1'b0, 1'b0);
    chk("bub_drop", 32'(drop_cnt), 32'd3);
    chk("bub_cnt",  32'(count),    32'd1);
    chk("bub_pc",   out_pc,        32'h100);

    // Full with simultaneous pop
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h300c, 32'hC3, 1'b0, 1'b1);
    chk("fullpop_cnt", 32'(count), 32'd3);

    // Async reset between edges with two entries held
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("pre_rst_cnt", 32'(count), 32'd2);
    in_valid = 0; out_ready = 0; flush = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_drop",  32'(drop_cnt),  32'd0);
    chk("arst_cnt",   32'(count),     32'd0);
    chk("arst_pc",    out_pc,         32'd0);
    #1 reset = 1'b0;
    mq.delete();
    m_drop = 0;
    @(posedge clk);
    #1;
    step(1'b1, 32'h4000, 32'hD0, 1'b0, 1'b0);
    chk("post_rst_push", 32'(count), 32'd1);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) step(1'b1, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        v, fl, ordy, bub;
      logic [31:0] pc, inst;
      v    = ($urandom_range(3, 0) != 0);
      fl   = ($urandom_range(15, 0) == 0);
      ordy = $urandom_range(1, 0) == 1;
      bub  = ($urandom_range(7, 0) == 0);
      pc   = bub ? 32'd0 : (($urandom_range(5, 0) == 0) ? 32'd0 : $urandom());
      inst = bub ? 32'd0 : (($urandom_range(5, 0) == 0) ? 32'd0 : $urandom());
      if (!bub && pc == 0 && inst == 0) inst = 32'h1;
      step(v, pc, inst, fl, ordy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; only the value 4 is supported.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-005 in_pc  input  32  PC of the presented instruction.
REQ-006 in_inst  input  32  presented instruction word.
REQ-007 in_ready  output  1  queue accepts a push this cycle.
REQ-008 flush  input  1  discard all queued entries (branch, jump or exception redirect).
REQ-009 out_ready  input  1  decode consumes the head entry this cycle.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_pc  output  32  PC of the head entry.
REQ-012 out_inst  output  32  instruction word of the head entry.
REQ-013 count  output  3  number of valid entries, 0..4.
REQ-014 drop_cnt  output  8  saturating count of bubbles filtered at the input.

Function
REQ-015 Storage SHALL be 4 entries of {pc[31:0], inst[31:0]}, addressed by 2-bit rd_ptr and wr_ptr that wrap 3->0.
REQ-016 in_ready SHALL equal (count < 4) and SHALL be independent of out_ready; a full queue never accepts a push, even in a cycle that also pops.
REQ-017 Push condition: in_valid & in_ready & !flush & !bubble, where bubble = (in_inst == 0 && in_pc == 0).
REQ-018 A push SHALL write the entry at wr_ptr on the rising edge, and SHALL then increment wr_ptr.
REQ-019 Pop condition: out_valid & out_ready & !flush; a pop SHALL increment rd_ptr.
REQ-020 A simultaneous push and pop with 0 < count < 4 SHALL leave count unchanged.
REQ-021 out_valid SHALL equal (count != 0).
REQ-022 When count == 0, out_pc and out_inst SHALL be 0, so decode sees a NOP.
REQ-023 When count != 0, out_pc and out_inst SHALL be the head entry, driven combinationally from storage, with zero-cycle read latency.
REQ-024 An entry pushed in cycle N SHALL first appear on the outputs in cycle N+1 when the queue was empty; there is no bypass from in_* to out_*.
REQ-025 Flush SHALL set count, rd_ptr and wr_ptr to 0 on the next edge, and SHALL ignore any push or pop in that cycle.
REQ-026 Flush overrides every other condition in the same cycle.
REQ-027 drop_cnt SHALL increment by 1 on each cycle with in_valid & bubble & !flush, and SHALL saturate at 255.
REQ-028 count SHALL never exceed 4 and never underflow.
REQ-029 A pop on an empty queue SHALL be a no-op, since out_valid is 0.
REQ-030 Entry contents need no clearing on flush; validity is defined solely by the pointers and count.

Reset
REQ-031 While reset is 1, regardless of clk: count=0, rd_ptr=0, wr_ptr=0, drop_cnt=0.
REQ-032 The resulting outputs SHALL be out_valid=0, out_pc=0, out_inst=0 and in_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-034 The first push is accepted on the first rising edge after reset deasserts.
REQ-035 The storage array needs no reset.

Verification
REQ-036 Fill/drain: out_ready=0; push pc 0xbfc00000/0x04/0x08/0x0c with inst 0x24010001..04.
  -> count=4 and in_ready=0; a fifth push is rejected.
  -> Then out_ready=1 for 4 cycles: outputs appear in order 0xbfc00000..0x0c, ending with count=0 and out_inst=0.
REQ-037 Wrap-around: 10 cycles of continuous push and pop with count held at 2.
  -> Pointers wrap, no entry is lost or duplicated, and the PC sequence is strictly in order.
REQ-038 Flush collision: count=3, and in one cycle assert flush, in_valid and out_ready together.
  -> Next cycle count=0 and out_valid=0; the pushed entry is absent.
REQ-039 Bubble filter: present in_valid=1 with pc=0 and inst=0 for 3 cycles, then pc=0x100 with inst=0.
  -> drop_cnt=3 and count=1; the pc=0x100 entry is accepted, because inst=0 with pc!=0 is a real NOP.
REQ-040 Full with pop: count=4, in_valid=1, out_ready=1.
  -> The pop occurs, the push is rejected, and count=3.
REQ-041 Async reset: count=2; pulse reset high between clock edges.
  -> out_valid falls to 0 before the next edge, and drop_cnt=0.
